// File: rtl/cfg_bank_pkg.sv
// Shared types and constants for the configuration register bank:
// unlock FSM state, default unlock key and the watchdog/BOD register map.
package cfg_bank_pkg;

    typedef enum logic {
        ST_LOCKED = 1'b0,
        ST_OPEN   = 1'b1
    } state_e;

    localparam logic [15:0] DEFAULT_UNLOCK_KEY = 16'hA5C3;

    // Register index map of the watchdog/BOD consumers
    localparam int unsigned REG_FWLEN   = 0;
    localparam int unsigned REG_SWLEN   = 1;
    localparam int unsigned REG_SERVICE = 2;
    localparam int unsigned REG_RST_LMT = 3;
    localparam int unsigned REG_BOD0    = 4;
    localparam int unsigned REG_BOD1    = 5;
    localparam int unsigned REG_BOD2    = 6;
    localparam int unsigned REG_BOD3    = 7;

endpackage

// File: rtl/cfg_unlock_fsm.sv
// Unlock state machine and timed window: decides which writes/commits are
// accepted, and when pending shadow edits must be discarded.
module cfg_unlock_fsm
    import cfg_bank_pkg::*;
#(
    parameter int unsigned UNLOCK_WIN = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic wren,
    input  logic commit,
    input  logic addr_is_reg,
    input  logic addr_is_key,
    input  logic key_ok,
    output logic locked,
    output logic wr_accept_c,
    output logic commit_ok_c,
    output logic relock_c,
    output logic expire_c,
    output logic err_c
);

    localparam int unsigned CNT_W = $clog2(UNLOCK_WIN + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOCKED;
            cnt_q    <= '0;
            locked_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_accept_c = 1'b0;
        commit_ok_c = 1'b0;
        relock_c    = 1'b0;
        expire_c    = 1'b0;
        err_c       = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (wren) begin
                    if (addr_is_key && key_ok) begin
                        state_d = ST_OPEN;
                        cnt_d   = CNT_W'(UNLOCK_WIN);
                    end else begin
                        err_c = 1'b1;
                    end
                end
                if (commit) begin
                    err_c = 1'b1;
                end
            end
            ST_OPEN: begin
                // Commit outranks every other event, a same-cycle register write merges into it
                if (commit) begin
                    commit_ok_c = 1'b1;
                    state_d     = ST_LOCKED;
                    cnt_d       = '0;
                    if (wren && addr_is_reg) begin
                        wr_accept_c = 1'b1;
                    end else if (wren && !addr_is_key) begin
                        err_c = 1'b1;
                    end
                end else if (wren && addr_is_key) begin
                    relock_c = 1'b1;
                    state_d  = ST_LOCKED;
                    cnt_d    = '0;
                end else if (wren && addr_is_reg) begin
                    wr_accept_c = 1'b1;
                    cnt_d       = CNT_W'(UNLOCK_WIN);
                end else begin
                    err_c = wren;
                    if (cnt_q <= CNT_W'(1)) begin
                        expire_c = 1'b1;
                        state_d  = ST_LOCKED;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOCKED;
                cnt_d   = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    assign locked = locked_q;

endmodule

// File: rtl/config_register_bank.sv
// Write-protected configuration register bank with shadow/active copies and atomic commit.
// Optional macro CFG_PARITY_EN adds per-register even parity and a sticky PERR output.
module config_register_bank
    import cfg_bank_pkg::*;
#(
    parameter int unsigned                 DATA_W       = 16,
    parameter int unsigned                 NUM_REGS     = 8,
    parameter int unsigned                 ADDR_W       = 4,
    parameter logic [DATA_W-1:0]           UNLOCK_KEY   = DATA_W'(DEFAULT_UNLOCK_KEY),
    parameter int unsigned                 UNLOCK_WIN   = 32,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALUES = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WREN,
    input  logic                         RDEN,
    input  logic [ADDR_W-1:0]            ABUS,
    input  logic [DATA_W-1:0]            DBUS,
    input  logic                         COMMIT,
    output logic [DATA_W-1:0]            RDATA,
    output logic                         RVALID,
    output logic                         WERR,
    output logic                         LOCKED,
    output logic                         COMMIT_DONE,
    output logic [NUM_REGS*DATA_W-1:0]   CFG
`ifdef CFG_PARITY_EN
    ,
    output logic                         PERR
`endif
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] KEY_ADDR = '1;

    logic [NUM_REGS-1:0][DATA_W-1:0] active_q, active_d, shadow_q, shadow_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, werr_q, werr_d, commit_done_q, commit_done_d;
    logic              addr_is_reg, addr_is_key, key_ok, locked;
    logic              wr_accept_c, commit_ok_c, relock_c, expire_c, err_c, rd_perr_c;
    logic [IDX_W-1:0]  reg_idx;

    assign addr_is_reg = (ABUS < ADDR_W'(NUM_REGS));
    assign addr_is_key = (ABUS == KEY_ADDR);
    assign key_ok      = (DBUS == UNLOCK_KEY);
    assign reg_idx     = IDX_W'(ABUS);

    cfg_unlock_fsm #(
        .UNLOCK_WIN (UNLOCK_WIN)
    ) u_fsm (
        .clk         (CLK),
        .rst         (RST),
        .wren        (WREN),
        .commit      (COMMIT),
        .addr_is_reg (addr_is_reg),
        .addr_is_key (addr_is_key),
        .key_ok      (key_ok),
        .locked      (locked),
        .wr_accept_c (wr_accept_c),
        .commit_ok_c (commit_ok_c),
        .relock_c    (relock_c),
        .expire_c    (expire_c),
        .err_c       (err_c)
    );

    // Shadow/active update; any relock restores the shadow from the active copy
    always_comb begin
        active_d = active_q;
        shadow_d = shadow_q;
        if (wr_accept_c) begin
            shadow_d[reg_idx] = DBUS;
        end
        if (commit_ok_c) begin
            active_d = shadow_d;
        end
        if (relock_c || expire_c) begin
            shadow_d = active_q;
        end
    end

    // Read path always returns the pre-edge active value
    always_comb begin
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        werr_d        = err_c;
        commit_done_d = commit_ok_c;
        if (RDEN) begin
            rvalid_d = 1'b1;
            if (addr_is_reg) begin
                rdata_d = active_q[reg_idx];
                werr_d  = werr_d | rd_perr_c;
            end else if (addr_is_key) begin
                rdata_d = DATA_W'(locked);
            end else begin
                rdata_d = '0;
                werr_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            active_q      <= RESET_VALUES;
            shadow_q      <= RESET_VALUES;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            werr_q        <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            werr_q        <= werr_d;
            commit_done_q <= commit_done_d;
        end
    end

`ifdef CFG_PARITY_EN
    logic [NUM_REGS-1:0] parity_q, parity_d, parity_rst, par_bad;
    logic                perr_q, perr_d;

    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            parity_rst[i] = ^RESET_VALUES[i*DATA_W +: DATA_W];
            parity_d[i]   = commit_ok_c ? (^active_d[i]) : parity_q[i];
            par_bad[i]    = (^active_q[i]) ^ parity_q[i];
        end
        perr_d = perr_q | (|par_bad);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            parity_q <= parity_rst;
            perr_q   <= 1'b0;
        end else begin
            parity_q <= parity_d;
            perr_q   <= perr_d;
        end
    end

    assign rd_perr_c = addr_is_reg & par_bad[reg_idx];
    assign PERR      = perr_q;
`else
    assign rd_perr_c = 1'b0;
`endif

    assign RDATA       = rdata_q;
    assign RVALID      = rvalid_q;
    assign WERR        = werr_q;
    assign LOCKED      = locked;
    assign COMMIT_DONE = commit_done_q;
    assign CFG         = active_q;

endmodule

// File: tb/tb_config_register_bank.sv
// Scoreboard bench for config_register_bank: a behavioural model predicts every
// cycle's outputs and each read's data; a monitor compares them as the DUT presents them.
module tb_config_register_bank;

    localparam int unsigned NREG = 8;
    localparam logic [3:0]  KEY  = 4'hF;
    localparam logic [15:0] UKEY = 16'hA5C3;
    localparam int          WIN  = 32;
    localparam logic [127:0] LEGACY = {16'h5555, 16'h000D, 16'h38E4, 16'h00CE,
                                       16'h000A, 16'h0010, 16'h000A, 16'h00FF};

    logic         CLK = 1'b0;
    logic         RST, WREN, RDEN, COMMIT;
    logic [3:0]   ABUS;
    logic [15:0]  DBUS;
    logic [15:0]  RDATA;
    logic         RVALID, WERR, LOCKED, COMMIT_DONE;
    logic [127:0] CFG;
`ifdef CFG_PARITY_EN
    logic         PERR;
`endif

    config_register_bank #(
        .DATA_W       (16),
        .NUM_REGS     (NREG),
        .ADDR_W       (4),
        .UNLOCK_KEY   (UKEY),
        .UNLOCK_WIN   (WIN),
        .RESET_VALUES (LEGACY)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WREN        (WREN),
        .RDEN        (RDEN),
        .ABUS        (ABUS),
        .DBUS        (DBUS),
        .COMMIT      (COMMIT),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .WERR        (WERR),
        .LOCKED      (LOCKED),
        .COMMIT_DONE (COMMIT_DONE),
        .CFG         (CFG)
`ifdef CFG_PARITY_EN
        ,
        .PERR        (PERR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         locked;
        logic         werr;
        logic         cdone;
        logic         rvalid;
        logic [15:0]  rdata;
        logic [127:0] cfg;
    } exp_t;

    exp_t        cq[$];
    logic [15:0] rq[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    logic [15:0] m_active[NREG];
    logic [15:0] m_shadow[NREG];
    logic [15:0] m_rdata;
    bit          m_open;
    int          m_win;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic model_step(input bit r, input bit w, input bit rd, input bit c,
                              input logic [3:0] a, input logic [15:0] d, output exp_t e);
        bit werr  = 1'b0;
        bit cdone = 1'b0;
        bit rv    = 1'b0;
        if (r) begin
            for (int i = 0; i < NREG; i++) begin
                m_active[i] = LEGACY[i*16 +: 16];
                m_shadow[i] = LEGACY[i*16 +: 16];
            end
            m_open  = 1'b0;
            m_win   = 0;
            m_rdata = 16'h0;
        end else begin
            if (rd) begin
                rv = 1'b1;
                if (a < 4'(NREG))  m_rdata = m_active[a];
                else if (a == KEY) m_rdata = {15'h0, !m_open};
                else begin
                    m_rdata = 16'h0;
                    werr    = 1'b1;
                end
            end
            if (!m_open) begin
                if (w) begin
                    if (a == KEY && d == UKEY) begin
                        m_open = 1'b1;
                        m_win  = WIN;
                    end else werr = 1'b1;
                end
                if (c) werr = 1'b1;
            end else if (c) begin
                if (w && a < 4'(NREG)) m_shadow[a] = d;
                else if (w && a != KEY) werr = 1'b1;
                m_active = m_shadow;
                m_open   = 1'b0;
                cdone    = 1'b1;
            end else if (w && a == KEY) begin
                m_shadow = m_active;
                m_open   = 1'b0;
            end else if (w && a < 4'(NREG)) begin
                m_shadow[a] = d;
                m_win       = WIN;
            end else begin
                if (w) werr = 1'b1;
                m_win = m_win - 1;
                if (m_win == 0) begin
                    m_shadow = m_active;
                    m_open   = 1'b0;
                end
            end
        end
        e.locked = !m_open;
        e.werr   = werr;
        e.cdone  = cdone;
        e.rvalid = rv;
        e.rdata  = m_rdata;
        for (int i = 0; i < NREG; i++) e.cfg[i*16 +: 16] = m_active[i];
    endtask

    // Drive one cycle of stimulus; expectations become visible after the next edge
    task automatic cyc(input bit r, input bit w, input bit rd, input bit c,
                       input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        RST = r; WREN = w; RDEN = rd; COMMIT = c; ABUS = a; DBUS = d;
        model_step(r, w, rd, c, a, d, e);
        @(posedge CLK);
        cq.push_back(e);
        if (rd && !r) rq.push_back(e.rdata);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    // Monitor: per-cycle scoreboard plus read-data queue popped on RVALID
    always @(negedge CLK) begin
        exp_t e;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("locked", 128'(LOCKED), 128'(e.locked));
            chk("werr", 128'(WERR), 128'(e.werr));
            chk("commit_done", 128'(COMMIT_DONE), 128'(e.cdone));
            chk("rvalid", 128'(RVALID), 128'(e.rvalid));
            chk("rdata_hold", 128'(RDATA), 128'(e.rdata));
            chk("cfg", CFG, e.cfg);
        end
        if (RVALID === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got RVALID=1 expected no read pending");
            end else begin
                chk("read_data", 128'(RDATA), 128'(rq.pop_front()));
            end
        end
    end

    initial begin
        RST = 1'b1; WREN = 1'b0; RDEN = 1'b0; COMMIT = 1'b0; ABUS = 4'h0; DBUS = 16'h0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
        chk("reset_cfg", CFG, LEGACY);
        chk("reset_locked", 128'(LOCKED), 128'(1'b1));
        chk("reset_rvalid", 128'(RVALID), 128'(1'b0));

        // Locked write rejected, then read back the default
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h1234);
        chk("locked_write_werr", 128'(WERR), 128'(1'b1));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
        chk("read0_default", 128'(RDATA), 128'(16'h00FF));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, KEY, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, 16'h1111);

        // Unlock, two writes, commit
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, UKEY);
        chk("unlocked", 128'(LOCKED), 128'(1'b0));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h1234);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 16'hBEEF);
        chk("shadow_not_visible", 128'(CFG[5*16 +: 16]), 128'(16'h38E4));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0);
        chk("commit_addr0", 128'(CFG[15:0]), 128'(16'h1234));
        chk("commit_addr5", 128'(CFG[5*16 +: 16]), 128'(16'hBEEF));
        chk("commit_done", 128'(COMMIT_DONE), 128'(1'b1));
        idle(2);

        // Unlock window expiry discards pending edits
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, UKEY);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 16'h0042);
        idle(WIN - 1);
        chk("window_still_open", 128'(LOCKED), 128'(1'b0));
        idle(1);
        chk("window_expired", 128'(LOCKED), 128'(1'b1));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0);
        chk("commit_after_expiry_werr", 128'(WERR), 128'(1'b1));
        chk("addr1_kept", 128'(CFG[1*16 +: 16]), 128'(16'h000A));

        // Write merged into commit
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, UKEY);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 16'h0077);
        chk("merged_commit", 128'(CFG[3*16 +: 16]), 128'(16'h0077));

        // Bad address while open, explicit relock, then reset with pending edits
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, UKEY);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 16'h0001);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 16'h9999);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, KEY, UKEY);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 16'h1111);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0);
        chk("reset_open_cfg", CFG, LEGACY);
        chk("reset_open_locked", 128'(LOCKED), 128'(1'b1));
        chk("reset_open_no_cdone", 128'(COMMIT_DONE), 128'(1'b0));

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            bit          r, w, rd, c;
            logic [3:0]  a;
            logic [15:0] d;
            r  = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 99) < 45);
            rd = ($urandom_range(0, 99) < 30);
            c  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 9))
                0, 1:    a = KEY;
                2:       a = 4'($urandom_range(8, 14));
                default: a = 4'($urandom_range(0, 7));
            endcase
            d = (a == KEY && $urandom_range(0, 3) != 0) ? UKEY : 16'($urandom);
            cyc(r, w, rd, c, a, d);
        end
        idle(3);
        #10;
        chk("exp_queue_drained", 128'(cq.size()), 128'(0));
        chk("read_queue_drained", 128'(rq.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
